// File: rtl/router_np_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : router_np_if                                               |
// | Description : Per-port bit-serial bundle for router_np. Input side       |
// |               carries frame_n / valid_n / di from the port serialisers,  |
// |               output side carries dout / valido_n / frameo_n towards     |
// |               the fabric, plus the per-input drop pulse.                 |
// |   master : drives frame_n, valid_n, di; observes dout/valido_n/frameo_n/ |
// |            drop                                                          |
// |   slave  : the router; receives frame_n, valid_n, di; drives the rest    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface router_np_if #(
    parameter int N_PORTS = 8
);
    logic [N_PORTS-1:0] frame_n;
    logic [N_PORTS-1:0] valid_n;
    logic [N_PORTS-1:0] di;
    logic [N_PORTS-1:0] dout;
    logic [N_PORTS-1:0] valido_n;
    logic [N_PORTS-1:0] frameo_n;
    logic [N_PORTS-1:0] drop;

    modport master (
        output frame_n, valid_n, di,
        input  dout, valido_n, frameo_n, drop
    );

    modport slave (
        input  frame_n, valid_n, di,
        output dout, valido_n, frameo_n, drop
    );
endinterface
`default_nettype wire

// File: rtl/router_np.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : router_np                                                  |
// | Description : N-port bit-serial packet router. Each input deserialises   |
// |               {addr, payload} frames, buffers them in a DEPTH-entry      |
// |               FIFO and each output round-robin grants the FIFO heads     |
// |               that target it, then re-serialises the payload LSB first.  |
// |               Overflowing or malformed packets pulse drop for one cycle. |
// | Ports       : clk_i   - clock, all logic on the rising edge              |
// |               rst_i   - synchronous active-high reset                    |
// |               bus_io  - router_np_if.slave, per-port serial in/out       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module router_np #(
    parameter int N_PORTS = 8,
    parameter int PW      = 32,
    parameter int DEPTH   = 2
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    router_np_if.slave      bus_io
);
    localparam int AW   = $clog2(N_PORTS);
    localparam int HW   = AW + PW;                       // FIFO entry {da, payload}
    localparam int CW   = $clog2(PW + 1);                // payload bit counter
    localparam int ACW  = $clog2(AW + 1);                // address bit counter
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEMN = 1 << PTRW;                     // storage sized to pointer range
    localparam int FCW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_PAD  = 2'd2,
        S_DATA = 2'd3
    } in_state_t;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic [N_PORTS-1:0]         pop;         // head of input i consumed this edge
    logic [N_PORTS-1:0]         fifo_empty;
    logic [N_PORTS*HW-1:0]      head_flat;   // FIFO head of each input
    logic [N_PORTS*N_PORTS-1:0] gnt_flat;    // [o*N_PORTS + i]: output o grants input i

    // Each input is popped by at most one output because a head has one destination.
    always_comb begin
        pop = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            pop = pop | gnt_flat[o*N_PORTS +: N_PORTS];
        end
    end

    // ------------------------------------------------------------------
    // Input side: deserialiser FSM + packet FIFO per port
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_PORTS; i++) begin : g_in
        in_state_t        state_q;
        logic [AW-1:0]    addr_q;
        logic [AW-1:0]    addr_d;
        logic [PW-1:0]    data_q;
        logic [PW-1:0]    data_d;
        logic [CW-1:0]    cnt_q;
        logic [ACW-1:0]   acnt_q;
        logic             done;
        logic             bad;
        logic             accept;
        logic             drop_q;

        logic [HW-1:0]    mem_q [MEMN];
        logic [PTRW-1:0]  wr_q;
        logic [PTRW-1:0]  rd_q;
        logic [FCW-1:0]   fcnt_q;

        // Both address and payload arrive LSB first, so shifting in from the
        // top leaves bit 0 at the LSB once all bits have been captured.
        always_comb begin
            addr_d         = addr_q >> 1;
            addr_d[AW-1]   = bus_io.di[i];
            data_d         = data_q >> 1;
            data_d[PW-1]   = bus_io.di[i];
            done           = 1'b0;
            bad            = 1'b0;
            case (state_q)
                S_ADDR, S_PAD: bad = bus_io.frame_n[i];
                S_DATA: begin
                    if (!bus_io.valid_n[i] && bus_io.frame_n[i]) begin
                        // cnt_q saturates at PW, so both short and over-long
                        // packets miss this exact count.
                        if (cnt_q == CW'(PW - 1)) begin
                            done = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // A full FIFO still takes the packet if its head leaves on the same edge.
        assign accept = done && ((fcnt_q != FCW'(DEPTH)) || pop[i]);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= S_IDLE;
                addr_q  <= '0;
                data_q  <= '0;
                cnt_q   <= '0;
                acnt_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // The cycle frame_n falls already carries address bit 0.
                        if (!bus_io.frame_n[i]) begin
                            addr_q <= addr_d;
                            acnt_q <= ACW'(1);
                            if (AW == 1) begin
                                state_q <= S_PAD;
                            end else begin
                                state_q <= S_ADDR;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (bus_io.frame_n[i]) begin
                            state_q <= S_IDLE;
                        end else begin
                            addr_q <= addr_d;
                            acnt_q <= acnt_q + 1'b1;
                            if (acnt_q == ACW'(AW - 1)) begin
                                state_q <= S_PAD;
                            end
                        end
                    end
                    S_PAD: begin
                        if (bus_io.frame_n[i]) begin
                            state_q <= S_IDLE;
                        end else if (!bus_io.valid_n[i]) begin
                            data_q  <= data_d;
                            cnt_q   <= CW'(1);
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (!bus_io.valid_n[i]) begin
                            if (bus_io.frame_n[i]) begin
                                state_q <= S_IDLE;
                            end else if (cnt_q != CW'(PW)) begin
                                data_q <= data_d;
                                cnt_q  <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept) begin
                mem_q[wr_q] <= {addr_q, data_d};
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_q   <= '0;
                rd_q   <= '0;
                fcnt_q <= '0;
                drop_q <= 1'b0;
            end else begin
                drop_q <= bad || (done && !accept);
                if (accept) begin
                    wr_q <= ptr_inc(wr_q);
                end
                if (pop[i]) begin
                    rd_q <= ptr_inc(rd_q);
                end
                case ({accept, pop[i]})
                    2'b10:   fcnt_q <= fcnt_q + 1'b1;
                    2'b01:   fcnt_q <= fcnt_q - 1'b1;
                    default: fcnt_q <= fcnt_q;
                endcase
            end
        end

        assign fifo_empty[i]             = (fcnt_q == '0);
        assign head_flat[i*HW +: HW]     = mem_q[rd_q];
        assign bus_io.drop[i]            = drop_q;
    end

    // ------------------------------------------------------------------
    // Output side: round-robin arbiter + payload serialiser per port
    // ------------------------------------------------------------------
    for (genvar o = 0; o < N_PORTS; o++) begin : g_out
        logic [AW-1:0]      rr_q;
        logic               busy_q;      // serialising or in the trailing idle cycle
        logic [CW-1:0]      bcnt_q;      // payload bits already driven
        logic [PW-1:0]      sreg_q;
        logic               dout_q;
        logic               valido_n_q;
        logic               frameo_n_q;
        logic [N_PORTS-1:0] gnt;
        logic               gnt_any;
        logic [AW-1:0]      gnt_idx;
        logic [AW-1:0]      cand;
        logic [PW-1:0]      gnt_pl;

        // AW-bit addition wraps the search modulo N_PORTS.
        always_comb begin
            gnt     = '0;
            gnt_any = 1'b0;
            gnt_idx = '0;
            cand    = '0;
            gnt_pl  = '0;
            if (!busy_q) begin
                for (int k = 0; k < N_PORTS; k++) begin
                    cand = rr_q + AW'(k);
                    if (!gnt_any && !fifo_empty[cand] &&
                        (head_flat[int'(cand)*HW + PW +: AW] == AW'(o))) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
                gnt_pl       = head_flat[int'(gnt_idx)*HW +: PW];
            end
        end

        assign gnt_flat[o*N_PORTS +: N_PORTS] = gnt;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_q       <= '0;
                busy_q     <= 1'b0;
                bcnt_q     <= '0;
                sreg_q     <= '0;
                dout_q     <= 1'b0;
                valido_n_q <= 1'b1;
                frameo_n_q <= 1'b1;
            end else if (gnt_any) begin
                // Bit 0 goes out on the grant edge itself.
                busy_q     <= 1'b1;
                bcnt_q     <= CW'(1);
                sreg_q     <= gnt_pl >> 1;
                dout_q     <= gnt_pl[0];
                valido_n_q <= 1'b0;
                frameo_n_q <= 1'b0;
                rr_q       <= gnt_idx + 1'b1;
            end else if (busy_q) begin
                if (bcnt_q == CW'(PW)) begin
                    // Mandatory idle cycle; the arbiter stays off until it ends.
                    busy_q     <= 1'b0;
                    dout_q     <= 1'b0;
                    valido_n_q <= 1'b1;
                    frameo_n_q <= 1'b1;
                end else begin
                    dout_q     <= sreg_q[0];
                    sreg_q     <= sreg_q >> 1;
                    valido_n_q <= 1'b0;
                    frameo_n_q <= (bcnt_q == CW'(PW - 1));
                    bcnt_q     <= bcnt_q + 1'b1;
                end
            end
        end

        assign bus_io.dout[o]     = dout_q;
        assign bus_io.valido_n[o] = valido_n_q;
        assign bus_io.frameo_n[o] = frameo_n_q;
    end
endmodule
`default_nettype wire

// File: doc/router_np.md
# router_np

Parametrised N-port serial packet router. It is the next generation of the fixed 8x8 switch and keeps the same per-port bit-serial frame/valid protocol. New capabilities: configurable port count and payload width, per-input packet buffering, per-output round-robin arbitration, and explicit drop reporting for overflow and malformed packets. It sits between the port serialisers and the switch fabric, and it is driven directly by the existing serial-protocol bench.

## Interface
- N_PORTS, 8, number of input and output ports; power of two, at least 2; AW = log2(N_PORTS)
- PW, 32, payload bits per packet; at least 2
- DEPTH, 2, packets buffered per input; at least 1
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- frame_n  in  N_PORTS  per-input frame, active low
- valid_n  in  N_PORTS  per-input payload valid, active low
- di  in  N_PORTS  per-input serial data
- dout  out  N_PORTS  per-output serial data
- valido_n  out  N_PORTS  per-output valid, active low
- frameo_n  out  N_PORTS  per-output frame, active low
- drop  out  N_PORTS  one-cycle pulse: the input's packet was discarded

## Operation
- Input packet format, LSB first: AW destination bits on consecutive cycles with frame_n low and valid_n high (first bit on the cycle frame_n falls). Then one or more pad cycles with valid_n high; di is ignored. Then PW payload bits on cycles with valid_n low. frame_n is high on the last payload bit.
- Input deserialiser FSM, one per port:
  - IDLE: go to ADDR when frame_n is low.
  - ADDR: go to PAD after AW bits.
  - PAD: go to DATA on the first cycle with valid_n low; that bit is payload bit 0.
  - DATA: a cycle with valid_n high stalls and captures nothing. On the cycle with valid_n low and frame_n high, the packet ends and the FSM returns to IDLE.
- Malformed packets: frame_n high while in ADDR or PAD, or an end with fewer than PW bits captured, discards the packet. The FSM returns to IDLE and drop pulses. Bits beyond PW before the end are also malformed and dropped.
- Buffering: each completed packet is written as {da, payload} into that input's DEPTH-entry FIFO.
  - The write is accepted if count < DEPTH, or if the same edge pops the head.
  - Otherwise the packet is discarded and drop pulses.
- Arbitration, per output:
  - An output is idle when it is not serialising.
  - An idle output grants the first input, searching from its rr pointer upward with wrap, whose non-empty FIFO head targets that output.
  - The grant pops the head, loads the output shift register, and sets rr = grant+1 mod N_PORTS.
  - Each head has exactly one destination, so there are no cross-output conflicts.
- Output: emits PW payload bits LSB first. The header is not forwarded. valido_n is low for all PW bits, frameo_n is low for bits 0..PW-2 and high on bit PW-1. Then at least one idle cycle follows (valido_n = frameo_n = 1) before the next grant.
- Ordering is preserved per input FIFO. Head-of-line blocking is accepted behaviour.

## Timing
- Reset values: dout = 0, valido_n = all 1, frameo_n = all 1, drop = 0. All FIFOs are empty, all FSMs are IDLE, all rr pointers are 0.
- Reset mid-packet: every partial input and in-flight output is abandoned. Outputs are inactive from the edge reset is sampled. No drop pulse is generated.
- The FIFO write occurs at edge E0, the edge sampling the last payload bit. drop for overflow or malformed packets is high for the cycle after E0.
- Uncontended latency: the head is visible after E0, the grant is registered at E0+1, and payload bit 0 appears on dout after E0+1.
- Output occupancy per packet: PW cycles active plus 1 idle cycle. The earliest next payload bit 0 is after edge (start + PW + 1).
- The arbiter evaluates only when the output is idle. A head arriving during serialisation waits for the idle cycle.

## Test plan
- Smoke (defaults): input 0 -> da 7, payload 0xDEADBEEF -> output 7 shows 32 bits equal to 0xDEADBEEF LSB first, bit 0 one cycle after E0, frameo_n high only on bit 31, all other outputs idle, drop = 0.
- Fan-out: input 0 sends to da 0..7 sequentially with distinct payloads -> each output receives exactly its own payload once, in order of sending.
- Contention: inputs 0,1,2,3 -> da 7, all ending at the same E0 -> output 7 grants 0,1,2,3 in order with one idle cycle between packets (33-cycle spacing). A follow-up with inputs 2 and 5 ending together, rr = 4 -> grant order 5 then 2.
- Overflow (DEPTH = 1): inputs 0,1,2 -> da 0 simultaneously, then input 2 immediately sends a second packet -> that packet is discarded, drop[2] pulses for one cycle, 3 packets appear on output 0.
- Malformed: frame_n rises during PAD on input 4; separately, input 5 ends after 16 payload bits -> drop[4] and drop[5] each pulse once, no output activity.
- Parametric + reset (N_PORTS = 4, PW = 16): 2-bit address to da 3, payload 0xA5C3 -> correct 16-bit output. Reset asserted mid-output -> valido_n and frameo_n return to 1 from the next edge, and the packet is not resumed after reset.
